sqr_core: RTL and testbench
===========================

# sqr_core

Multi-cycle integer squaring engine that sits directly behind the SQR AXI4-Lite register slave. The slave writes an operand and a start strobe. sqr_core computes operand² with a shift-add datapath in a fixed number of cycles. It then returns the result and a done pulse, which the slave exposes through its read-back registers. There is no bus logic inside this block; the interface is a plain start/busy/done handshake.

## Interface
Parameters:
- DATA_WIDTH, 16, operand width in bits (2..32); result is 2*DATA_WIDTH bits.

Ports:
- ACLK  in  1  system clock; all logic on the rising edge.
- ARESETN  in  1  reset, synchronous, active-low.
- start  in  1  request pulse; sampled when ACLK rises.
- abort  in  1  cancel the computation in progress.
- operand  in  DATA_WIDTH  unsigned value to square; captured only on an accepted start.
- busy  out  1  high while the computation is running.
- done  out  1  one-cycle pulse when result is updated.
- result_valid  out  1  sticky; result holds a completed square.
- result  out  2*DATA_WIDTH  last completed square.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, start=1, abort=0:
  - Capture operand into A (2*DATA_WIDTH bits, zero-extended) and into B (DATA_WIDTH bits).
  - Clear acc (2*DATA_WIDTH bits) and cnt (bit counter).
  - Clear result_valid.
  - Go to CALC.
- IDLE, start=1, abort=1: abort wins. The start is dropped and the state stays IDLE.
- CALC, each cycle:
  - If B[0]=1, set acc = acc + A (modulo 2^(2*DATA_WIDTH); acc cannot overflow because the operand is unsigned).
  - Shift A left by 1 and B right by 1; increment cnt.
  - When cnt reaches DATA_WIDTH-1 in this step, go to DONE.
- CALC with abort=1: go to IDLE next cycle. acc is discarded, no done pulse, result and result_valid stay unchanged (result_valid is already 0).
- CALC with start=1: ignored; operand is not re-sampled.
- DONE:
  - Load result from acc; set done=1 for this cycle only; set result_valid=1.
  - Return to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE, so back-to-back operation has no bubble beyond DONE.
  - abort in DONE is ignored; the result still commits.
- result keeps its value until the next DONE. It is not cleared by start or abort.

## Timing
- Reset (ARESETN=0 at a rising edge) gives state=IDLE, busy=0, done=0, result_valid=0, result=0, and clears acc, A, B and cnt.
- Reset applied mid-CALC or in DONE takes priority over every other input; no done is produced.
- busy and done are registered outputs (no combinational path from start).
- Start accepted at edge k:
  - busy=1 for cycles k+1 .. k+DATA_WIDTH (DATA_WIDTH cycles).
  - done=1 and the new result appear in cycle k+DATA_WIDTH+1; busy=0 in that cycle.
- Total latency from start to done is DATA_WIDTH+1 cycles, independent of operand value. There is no early termination.
- Throughput: one result per DATA_WIDTH+1 cycles when start is held high continuously.
- Abort sampled at edge m during CALC gives busy=0 from cycle m+1.

## Test plan
- DATA_WIDTH=16, operand=3, one-cycle start at edge 10:
  - busy high in cycles 11..26.
  - done pulse in cycle 27 with result=0x00000009 and result_valid=1.
- operand=0xFFFF gives result=0xFFFE0001.
- operand=0 gives result=0.
- Back-to-back: operand=0x1234 then 0x00FF, with the second start asserted in the DONE cycle.
  - First result is 0x014B5A90; second result is 0x0000FE01.
  - The second done arrives 17 cycles after the first.
- Start at edge 10 with operand=5, then start at edge 15 with operand=7:
  - The second start is ignored.
  - done arrives in cycle 27 with result=0x19.
- Abort and reset:
  - Complete operand=5 (result=0x19). Then start operand=9 and assert abort 4 cycles later.
  - Required: busy drops the next cycle, no done, result stays 0x19, result_valid=0.
  - Then start operand=9 again and assert ARESETN=0 mid-CALC.
  - Required: all outputs are 0 on the next cycle, and no done is produced.

Source files
------------

// File: rtl/sqr_core_if.sv
// Start/busy/done handshake between the SQR register slave and the squaring engine.
// The slave side (sqr_core) receives the operand and returns the result and status.
interface sqr_core_if #(
    parameter int DATA_WIDTH = 16
);
    logic                      start;
    logic                      abort;
    logic [DATA_WIDTH-1:0]     operand;
    logic                      busy;
    logic                      done;
    logic                      result_valid;
    logic [2*DATA_WIDTH-1:0]   result;

    modport master (
        output start, abort, operand,
        input  busy, done, result_valid, result
    );

    modport slave (
        input  start, abort, operand,
        output busy, done, result_valid, result
    );
endinterface

// File: rtl/sqr_core.sv
// Multi-cycle shift-add squaring engine: DATA_WIDTH accumulate steps, then a one-cycle DONE.
// The result register holds the last completed square until the next one commits.
module sqr_core #(
    parameter int DATA_WIDTH = 16
) (
    input  logic      ACLK,
    input  logic      ARESETN,
    sqr_core_if.slave bus
);
    localparam int RW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state, state_nxt;
    logic [RW-1:0]         a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [RW-1:0]         acc_q;
    logic [CW-1:0]         cnt_q;
    logic [RW-1:0]         result_q;
    logic                  result_valid_q;

    logic                  accept;
    logic                  last_step;
    logic [RW-1:0]         acc_sum;

    // DONE accepts a new start just like IDLE, which removes the bubble between jobs.
    assign accept    = (state == IDLE || state == DONE) && bus.start && !bus.abort;
    assign last_step = (state == CALC) && !bus.abort && (cnt_q == LAST_CNT);
    assign acc_sum   = b_q[0] ? acc_q + a_q : acc_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first so no path through this block can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: begin
                if (bus.abort)      state_nxt = IDLE;
                else if (last_step) state_nxt = DONE;
            end
            DONE:    state_nxt = accept ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            CALC:    bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // The final accumulate step commits straight into result so it is visible during DONE.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            a_q            <= '0;
            b_q            <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else if (accept) begin
            a_q            <= RW'(bus.operand);
            b_q            <= bus.operand;
            acc_q          <= '0;
            cnt_q          <= '0;
            result_valid_q <= 1'b0;
        end else if (state == CALC && !bus.abort) begin
            acc_q <= acc_sum;
            a_q   <= {a_q[RW-2:0], 1'b0};
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + CW'(1);
            if (last_step) begin
                result_q       <= acc_sum;
                result_valid_q <= 1'b1;
            end
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
endmodule

// File: tb/tb_sqr_core.sv
// Self-checking bench for sqr_core: a countdown/product model checked every cycle,
// plus directed scenarios with hand-computed squares and latencies.
module tb_sqr_core;
    localparam int DW = 16;
    localparam int RW = 2 * DW;

    logic ACLK = 1'b0;
    logic ARESETN;

    sqr_core_if #(.DATA_WIDTH(DW)) bus ();

    sqr_core #(.DATA_WIDTH(DW)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;
    bit cmp_en   = 1'b0;

    always @(posedge ACLK) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a job is a countdown of DW busy cycles; when it expires the square appears.
    int            m_remaining = 0;
    logic [RW-1:0] m_pend      = '0;
    logic [RW-1:0] m_result    = '0;
    bit            m_valid     = 1'b0;
    bit            m_done      = 1'b0;

    always @(posedge ACLK) begin
        int prev;
        logic [63:0] prod;
        if (!ARESETN) begin
            m_remaining = 0;
            m_result    = '0;
            m_valid     = 1'b0;
            m_done      = 1'b0;
        end else begin
            prev   = m_remaining;
            m_done = 1'b0;
            if (prev > 0) begin
                if (bus.abort) begin
                    m_remaining = 0;
                end else begin
                    m_remaining = prev - 1;
                    if (m_remaining == 0) begin
                        m_done   = 1'b1;
                        m_result = m_pend;
                        m_valid  = 1'b1;
                    end
                end
            end else if (bus.start && !bus.abort) begin
                prod        = {48'b0, bus.operand} * {48'b0, bus.operand};
                m_pend      = prod[RW-1:0];
                m_remaining = DW;
                m_valid     = 1'b0;
            end
        end
    end

    always @(negedge ACLK) begin
        if (cmp_en) begin
            check("busy",         bus.busy,         m_remaining > 0);
            check("done",         bus.done,         m_done);
            check("result_valid", bus.result_valid, m_valid);
            check("result",       bus.result,       m_result);
        end
    end

    // Pulse start for one edge; returns 1 time unit after the sampling edge.
    task automatic do_start(input logic [DW-1:0] op, output int s_edge);
        bus.start   = 1'b1;
        bus.operand = op;
        @(posedge ACLK);
        #1;
        s_edge    = edge_cnt;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int d_edge, output logic [RW-1:0] res);
        bit seen = 1'b0;
        d_edge = -1;
        res    = '0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge ACLK);
            #1;
            if (bus.done === 1'b1) begin
                seen   = 1'b1;
                d_edge = edge_cnt;
                res    = bus.result;
            end
        end
        check("done_seen", seen, 1'b1);
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        bit saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge ACLK);
            #1;
            if (bus.done !== 1'b0) saw = 1'b1;
        end
        check(name, saw, 1'b0);
    endtask

    initial begin
        int s_edge, d_edge, d_edge2, s2;
        logic [RW-1:0] res;

        ARESETN     = 1'b0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.operand = '0;
        @(posedge ACLK);
        #1;
        cmp_en = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        check("rst_busy",   bus.busy,         1'b0);
        check("rst_done",   bus.done,         1'b0);
        check("rst_valid",  bus.result_valid, 1'b0);
        check("rst_result", bus.result,       '0);
        ARESETN = 1'b1;

        // operand=3 sampled at edge 10: busy right after, done visible after edge 26 (cycle 27)
        while (edge_cnt < 9) begin
            @(posedge ACLK);
            #1;
        end
        do_start(16'd3, s_edge);
        check("t1_start_edge", s_edge, 10);
        check("t1_busy_c11", bus.busy, 1'b1);
        wait_done(d_edge, res);
        check("t1_done_edge", d_edge, 26);
        check("t1_result", res, 32'h0000_0009);
        check("t1_valid", bus.result_valid, 1'b1);

        do_start(16'hFFFF, s_edge);
        wait_done(d_edge, res);
        check("ffff_result", res, 32'hFFFE_0001);
        check("ffff_latency", d_edge - s_edge, DW);

        do_start(16'h0000, s_edge);
        wait_done(d_edge, res);
        check("zero_result", res, 32'h0);

        // Back-to-back: second start presented during the DONE cycle
        do_start(16'h1234, s_edge);
        wait_done(d_edge, res);
        check("b2b_first", res, 32'h014B_5A90);
        do_start(16'h00FF, s2);
        wait_done(d_edge2, res);
        check("b2b_second", res, 32'h0000_FE01);
        check("b2b_spacing", d_edge2 - d_edge, 17);

        // Start during CALC is ignored
        do_start(16'd5, s_edge);
        repeat (3) @(posedge ACLK);
        #1;
        do_start(16'd7, s2);
        check("ign_start_offset", s2 - s_edge, 4);
        wait_done(d_edge, res);
        check("ign_result", res, 32'h19);
        check("ign_latency", d_edge - s_edge, DW);

        // start together with abort in IDLE: abort wins
        bus.abort = 1'b1;
        do_start(16'd9, s_edge);
        bus.abort = 1'b0;
        check("idle_abort_busy", bus.busy, 1'b0);

        // Abort 4 cycles into CALC
        do_start(16'd9, s_edge);
        repeat (3) @(posedge ACLK);
        #1;
        bus.abort = 1'b1;
        @(posedge ACLK);
        #1;
        bus.abort = 1'b0;
        check("abort_edge", edge_cnt - s_edge, 4);
        check("abort_busy",   bus.busy,         1'b0);
        check("abort_done",   bus.done,         1'b0);
        check("abort_result", bus.result,       32'h19);
        check("abort_valid",  bus.result_valid, 1'b0);
        watch_no_done("abort_no_done", 25);

        // Synchronous reset mid-CALC
        do_start(16'd9, s_edge);
        repeat (5) @(posedge ACLK);
        #1;
        ARESETN = 1'b0;
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        check("mid_rst_busy",   bus.busy,         1'b0);
        check("mid_rst_done",   bus.done,         1'b0);
        check("mid_rst_valid",  bus.result_valid, 1'b0);
        check("mid_rst_result", bus.result,       32'h0);
        watch_no_done("mid_rst_no_done", 25);

        // Recovery after reset
        do_start(16'h00FF, s_edge);
        wait_done(d_edge, res);
        check("recover_result", res, 32'h0000_FE01);

        repeat (3) @(posedge ACLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
